// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared defines for the register-file writeback path. The register file and
// the writeback arbiter both take their geometry from here so the two always
// agree.
//
// Contents:
//   REG_NUM  - number of architectural registers
//   ADDR_W   - register address width
//   DATA_W   - register data width
//   SRC_ALU  - writeback source index of the ALU (source 0)
//   SRC_LSU  - writeback source index of the LSU (source 1)
//   src_e    - enumerated writeback source, used for the last-grant pointer
//   pick_lsu - round-robin choice between the two holding buffers
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;

    typedef enum logic {
        GRANT_ALU = 1'(SRC_ALU),
        GRANT_LSU = 1'(SRC_LSU)
    } src_e;

    // Returns 1 when the LSU buffer should win this cycle. With only one
    // buffer occupied that buffer wins; with both occupied the source that
    // did not win last time goes next.
    function automatic logic pick_lsu(input logic alu_held,
                                      input logic lsu_held,
                                      input src_e last_grant);
        logic lsu_wins;
        lsu_wins = 1'b0;
        if (lsu_held && !alu_held) begin
            lsu_wins = 1'b1;
        end else if (lsu_held && alu_held) begin
            lsu_wins = (last_grant == GRANT_ALU);
        end
        return lsu_wins;
    endfunction

endpackage

// File: rtl/wb_arbiter_hold_buf.sv
// ---------------------------------------------------------------------------
// wb_hold_buf
// One-entry holding buffer for a single writeback source. A request is taken
// whenever the buffer is empty or is being drained this cycle, so a source
// that keeps its valid high can stream one write per grant with no bubble.
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_valid/in_addr/in_data- incoming writeback request
//   in_ready                - request accepted this cycle when in_valid && in_ready
//   grant                   - arbiter grant: entry is consumed at this edge
//   hold_valid/addr/data    - current buffer contents
// ---------------------------------------------------------------------------
module wb_hold_buf
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = wb_arbiter_pkg::ADDR_W,
    parameter int DATA_W = wb_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              grant,
    output logic              hold_valid,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_data
);

    // Ready is forced high during reset so upstream sees an idle, open port.
    // Reset still dominates the load below, so nothing is captured then.
    assign in_ready = rst || !hold_valid || grant;

    // Load on accept (this also covers reload of an entry granted this same
    // cycle); otherwise a grant frees the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_addr  <= in_addr;
            hold_data  <= in_data;
        end else if (grant) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter and register scoreboard. Two sources (ALU, LSU) each own
// a one-entry holding buffer; one occupied buffer per cycle is granted the
// single register-file write port, round-robin on ties. The scoreboard keeps
// one busy bit per register, set at issue and cleared by the writeback.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   s0_valid/addr/data, s0_ready   - ALU writeback request / accept
//   s1_valid/addr/data, s1_ready   - LSU writeback request / accept
//   iss_valid, iss_rd, iss_ready   - issue handshake marking rd pending
//   q_addr1/2, q_busy1/2           - operand busy queries (write-through aware)
//   write_request, w_addr, w_data  - register-file write port
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REG_NUM = wb_arbiter_pkg::REG_NUM,
    parameter int ADDR_W  = wb_arbiter_pkg::ADDR_W,
    parameter int DATA_W  = wb_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              write_request,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);

    logic              h0_valid;
    logic [ADDR_W-1:0] h0_addr;
    logic [DATA_W-1:0] h0_data;
    logic              h1_valid;
    logic [ADDR_W-1:0] h1_addr;
    logic [DATA_W-1:0] h1_data;

    logic              grant0;
    logic              grant1;
    logic              grant_any;
    src_e              last_grant;

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;
    logic               iss_fire;

    // ------------------------------------------------------------------
    // Holding buffers, one per source
    // ------------------------------------------------------------------
    wb_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_alu (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s0_valid),
        .in_addr    (s0_addr),
        .in_data    (s0_data),
        .in_ready   (s0_ready),
        .grant      (grant0),
        .hold_valid (h0_valid),
        .hold_addr  (h0_addr),
        .hold_data  (h0_data)
    );

    wb_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_lsu (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s1_valid),
        .in_addr    (s1_addr),
        .in_data    (s1_data),
        .in_ready   (s1_ready),
        .grant      (grant1),
        .hold_valid (h1_valid),
        .hold_addr  (h1_addr),
        .hold_data  (h1_data)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // Grants depend only on buffer state and the pointer, never on the
    // incoming valids, so write_request has no path from sN_valid. Grants
    // are suppressed while rst is high so nothing reaches the register
    // file during reset even though the buffers empty only at the edge.
    // ------------------------------------------------------------------
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        grant_any = 1'b0;
        if (!rst) begin
            grant1    = pick_lsu(h0_valid, h1_valid, last_grant);
            grant0    = h0_valid && !grant1;
            grant_any = grant0 || grant1;
        end
    end

    // Write-port mux. An entry addressed to x0 is still granted (so it
    // drains and moves the pointer) but never raises write_request.
    always_comb begin
        w_addr        = '0;
        w_data        = '0;
        write_request = 1'b0;
        if (grant1) begin
            w_addr = h1_addr;
            w_data = h1_data;
        end else if (grant0) begin
            w_addr = h0_addr;
            w_data = h0_data;
        end
        write_request = grant_any && (w_addr != '0);
    end

    // Last-grant pointer. Resetting to the LSU makes the ALU win the first
    // tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_LSU;
        end else if (grant0) begin
            last_grant <= GRANT_ALU;
        end else if (grant1) begin
            last_grant <= GRANT_LSU;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // Issue stalls on a pending write to the same rd (WAW). x0 is never
    // tracked.
    // ------------------------------------------------------------------
    assign iss_ready = rst || (iss_rd == '0) || !busy[iss_rd];
    assign iss_fire  = !rst && iss_valid && iss_ready && (iss_rd != '0);

    // Clear from the writeback is applied first so that a set from an issue
    // to the same register on the same edge wins.
    always_comb begin
        busy_next = busy;
        if (write_request) begin
            busy_next[w_addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Queries see a register being written this cycle as already free,
    // matching the register file's write-through forwarding.
    always_comb begin
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        if (!rst) begin
            q_busy1 = (q_addr1 != '0) && busy[q_addr1]
                      && !(write_request && (w_addr == q_addr1));
            q_busy2 = (q_addr2 != '0) && busy[q_addr2]
                      && !(write_request && (w_addr == q_addr2));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed self-checking bench for wb_arbiter. Inputs are driven 1 time unit
// after the rising edge, outputs are checked 1 time unit later, well clear of
// the next edge.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              s0_valid;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_busy1;
    logic              q_busy2;
    logic              write_request;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    int checks;
    int errors;

    wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .s0_valid      (s0_valid),
        .s0_addr       (s0_addr),
        .s0_data       (s0_data),
        .s0_ready      (s0_ready),
        .s1_valid      (s1_valid),
        .s1_addr       (s1_addr),
        .s1_data       (s1_data),
        .s1_ready      (s1_ready),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_ready     (iss_ready),
        .q_addr1       (q_addr1),
        .q_addr2       (q_addr2),
        .q_busy1       (q_busy1),
        .q_busy2       (q_busy2),
        .write_request (write_request),
        .w_addr        (w_addr),
        .w_data        (w_data)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s0v, input logic [ADDR_W-1:0] s0a,
                                 input logic [DATA_W-1:0] s0d,
                                 input logic s1v, input logic [ADDR_W-1:0] s1a,
                                 input logic [DATA_W-1:0] s1d,
                                 input logic iv, input logic [ADDR_W-1:0] ird,
                                 input logic [ADDR_W-1:0] qa1,
                                 input logic [ADDR_W-1:0] qa2);
        s0_valid  = s0v;
        s0_addr   = s0a;
        s0_data   = s0d;
        s1_valid  = s1v;
        s1_addr   = s1a;
        s1_data   = s1d;
        iss_valid = iv;
        iss_rd    = ird;
        q_addr1   = qa1;
        q_addr2   = qa2;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Expected grant sequence with both sources streaming after reset
    logic [ADDR_W-1:0] expAddr [4];
    logic [DATA_W-1:0] expData [4];
    logic              expS0r  [4];
    logic              expS1r  [4];

    initial begin
        checks = 0;
        errors = 0;
        expAddr = '{5'd1, 5'd2, 5'd1, 5'd2};
        expData = '{32'h100, 32'h200, 32'h101, 32'h202};
        expS0r  = '{1'b1, 1'b0, 1'b1, 1'b0};
        expS1r  = '{1'b0, 1'b1, 1'b0, 1'b1};

        // ---- Reset-state outputs while rst is high
        rst = 1'b1;
        applyStimulus(1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB, 1, 5'd6, 5'd6, 5'd3);
        tick();
        applyStimulus(1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB, 1, 5'd6, 5'd6, 5'd3);
        checkOutput("rst_wreq", write_request, 0);
        checkOutput("rst_waddr", w_addr, 0);
        checkOutput("rst_wdata", w_data, 0);
        checkOutput("rst_s0r", s0_ready, 1);
        checkOutput("rst_s1r", s1_ready, 1);
        checkOutput("rst_issr", iss_ready, 1);
        checkOutput("rst_qb1", q_busy1, 0);
        checkOutput("rst_qb2", q_busy2, 0);
        tick();
        rst = 1'b0;
        idle();
        checkOutput("post_rst_wreq", write_request, 0);

        // ---- Single ALU writeback to x5 with x5 pending
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
        checkOutput("iss5_ready", iss_ready, 1);
        tick();
        applyStimulus(1, 5'd5, 32'h11, 0, 0, 0, 0, 0, 5'd5, 0);
        checkOutput("x5_busy", q_busy1, 1);
        checkOutput("x5_accept_wreq", write_request, 0);
        checkOutput("x5_s0r", s0_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
        checkOutput("x5_wreq", write_request, 1);
        checkOutput("x5_waddr", w_addr, 5);
        checkOutput("x5_wdata", w_data, 32'h11);
        checkOutput("x5_fwd_qb1", q_busy1, 0);
        tick();
        idle();
        q_addr1 = 5'd5;
        #1;
        checkOutput("x5_done_wreq", write_request, 0);
        checkOutput("x5_cleared", q_busy1, 0);

        // ---- Both sources streaming: grants alternate from s0
        doReset();
        applyStimulus(1, 5'd1, 32'h100, 1, 5'd2, 32'h200, 0, 0, 0, 0);
        checkOutput("rr0_wreq", write_request, 0);
        checkOutput("rr0_s0r", s0_ready, 1);
        checkOutput("rr0_s1r", s1_ready, 1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 5'd1, 32'h100 + 32'(k), 1, 5'd2, 32'h200 + 32'(k),
                          0, 0, 0, 0);
            checkOutput($sformatf("rr%0d_wreq", k), write_request, 1);
            checkOutput($sformatf("rr%0d_waddr", k), w_addr, expAddr[k-1]);
            checkOutput($sformatf("rr%0d_wdata", k), w_data, expData[k-1]);
            checkOutput($sformatf("rr%0d_s0r", k), s0_ready, expS0r[k-1]);
            checkOutput($sformatf("rr%0d_s1r", k), s1_ready, expS1r[k-1]);
            tick();
        end

        // ---- Scoreboard: issue, WAW stall, writeback with forwarding
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        checkOutput("iss7_ready", iss_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7);
        checkOutput("x7_qb1", q_busy1, 1);
        checkOutput("x7_qb2", q_busy2, 1);
        checkOutput("x7_waw_stall", iss_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h77, 0, 5'd7, 5'd7, 5'd7);
        checkOutput("x7_still_busy", q_busy1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7);
        checkOutput("x7_wreq", write_request, 1);
        checkOutput("x7_waddr", w_addr, 7);
        checkOutput("x7_wdata", w_data, 32'h77);
        checkOutput("x7_fwd_qb1", q_busy1, 0);
        checkOutput("x7_fwd_qb2", q_busy2, 0);
        tick();
        checkOutput("x7_iss_ready", iss_ready, 1);
        checkOutput("x7_clear_qb1", q_busy1, 0);

        // ---- Issue and writeback of x9 on the same edge: set wins
        doReset();
        applyStimulus(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0);
        checkOutput("x9_wreq", write_request, 1);
        checkOutput("x9_waddr", w_addr, 9);
        checkOutput("x9_iss_ready", iss_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
        checkOutput("x9_busy_after", q_busy1, 1);
        checkOutput("x9_done_wreq", write_request, 0);

        // ---- LSU write to x0 drains without a write, then reloads
        doReset();
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hFF, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd8, 32'h88, 0, 0, 0, 0);
        checkOutput("x0_wreq", write_request, 0);
        checkOutput("x0_s1r", s1_ready, 1);
        tick();
        idle();
        checkOutput("x8_wreq", write_request, 1);
        checkOutput("x8_waddr", w_addr, 8);
        checkOutput("x8_wdata", w_data, 32'h88);
        tick();
        checkOutput("x8_done_wreq", write_request, 0);
        checkOutput("x8_s1r", s1_ready, 1);

        // ---- Mid-operation reset with both buffers full and busy bits set
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0);
        tick();
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 5'd3, 5'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
        checkOutput("full_s1r", s1_ready, 0);
        checkOutput("full_qb2", q_busy2, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wreq", write_request, 0);
        checkOutput("midrst_s0r", s0_ready, 1);
        checkOutput("midrst_s1r", s1_ready, 1);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("after_rst_wreq", write_request, 0);
        checkOutput("after_rst_qb1", q_busy1, 0);
        checkOutput("after_rst_qb2", q_busy2, 0);
        checkOutput("after_rst_s0r", s0_ready, 1);
        checkOutput("after_rst_s1r", s1_ready, 1);
        tick();
        checkOutput("after_rst2_wreq", write_request, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 32, the number of architectural registers.
REQ-002 The block SHALL have parameter ADDR_W, default 5, the register address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, the register data width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-006 The block SHALL have ports s0_valid/s1_valid, input, 1, writeback request from source 0 (ALU) and source 1 (LSU).
REQ-007 The block SHALL have ports s0_addr/s1_addr, input, ADDR_W, destination register of each request.
REQ-008 The block SHALL have ports s0_data/s1_data, input, DATA_W, writeback data of each request.
REQ-009 The block SHALL have ports s0_ready/s1_ready, output, 1, request accepted this cycle when valid && ready.
REQ-010 The block SHALL have ports iss_valid (input, 1), iss_rd (input, ADDR_W) and iss_ready (output, 1), the issue handshake that marks rd pending.
REQ-011 The block SHALL have ports q_addr1/q_addr2 (input, ADDR_W) and q_busy1/q_busy2 (output, 1), the scoreboard operand queries.
REQ-012 The block SHALL have ports write_request (output, 1), w_addr (output, ADDR_W) and w_data (output, DATA_W), driving the register-file write port.

Function
REQ-013 Each source SHALL own a one-entry holding buffer (valid, addr, data); sN_ready = !holdN_valid || holdN granted this cycle.
REQ-014 An accepted request SHALL load the buffer at the edge of acceptance; the earliest write-port drive is the following cycle (1-cycle latency).
REQ-015 Exactly one occupied buffer SHALL be granted per cycle; if only one is occupied, it is granted.
REQ-016 If both buffers are occupied, the source not granted last SHALL be granted (round-robin, last-grant pointer updated on every grant).
REQ-017 The granted buffer SHALL drive w_addr/w_data combinationally; write_request = grant && w_addr != 0.
REQ-018 A granted entry with addr 0 SHALL be drained (buffer freed, pointer updated) without asserting write_request.
REQ-019 A granted buffer SHALL be freed at the edge; a simultaneous new accept into it SHALL reload it (no bubble).
REQ-020 The scoreboard SHALL hold REG_NUM busy bits; bit 0 is hard-wired 0.
REQ-021 iss_ready SHALL equal (iss_rd == 0) || !busy[iss_rd] (WAW stall); on iss_valid && iss_ready with iss_rd != 0, busy[iss_rd] is set at the edge.
REQ-022 write_request SHALL clear busy[w_addr] at the edge; if the same edge also sets busy on the same register, set wins.
REQ-023 q_busyN SHALL equal busy[q_addrN] && !(write_request && w_addr == q_addrN), consistent with register-file write-through forwarding; q_addrN == 0 gives 0.
REQ-024 All outputs SHALL be combinational from state and current inputs; no input-to-output path SHALL pass through sN_valid into write_request.

Reset
REQ-025 While rst is high at an edge, both buffers SHALL empty, all busy bits SHALL clear and the pointer SHALL be set so source 0 wins the first tie.
REQ-026 During reset, write_request SHALL be 0, w_addr/w_data SHALL be 0, s0_ready/s1_ready SHALL be 1, iss_ready SHALL be 1 and q_busy1/q_busy2 SHALL be 0.
REQ-027 Buffered writes pending at a mid-operation reset SHALL be discarded, never written.

Structure
REQ-028 REG_NUM, ADDR_W, DATA_W and source-index constants (SRC_ALU=0, SRC_LSU=1) SHALL live in the shared defines package used by reg_file.
REQ-029 The one-entry holding buffer SHALL be a sub-module wb_hold_buf, instantiated once per source; arbitration and scoreboard stay in wb_arbiter.

Verification
REQ-030 The bench SHALL cover: s0 writes x5=0x11 alone -> next cycle write_request=1, w_addr=5, w_data=0x11; busy[5] cleared after that edge.
REQ-031 The bench SHALL cover: both sources valid every cycle (s0 x1, s1 x2) -> grants alternate s0, s1, s0 starting with s0 after reset; each sN_ready low only while its buffer is held and not granted.
REQ-032 The bench SHALL cover: issue x7 -> q_busy1(q_addr1=7)=1; a second issue to x7 -> iss_ready=0; writeback x7 -> q_busy1=0 in the same cycle and iss_ready=1.
REQ-033 The bench SHALL cover: issue x9 in the same cycle as writeback x9 -> busy[9]=1 afterwards.
REQ-034 The bench SHALL cover: s1 writes x0=0xFF -> write_request stays 0, buffer drains in one cycle, s1_ready returns to 1.
REQ-035 The bench SHALL cover: both buffers full with busy bits set, rst pulsed one cycle -> no write issued afterwards, all q_busy=0, sN_ready=1.
